// File: rtl/matrix_result_drain_if.sv
// Element stream from matrix_result_drain to the host-side writer / DMA.
interface matrix_result_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_eol;
  logic        out_last;

  modport master (output out_valid, out_data, out_eol, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_eol, out_last, output out_ready);
endinterface

// File: rtl/matrix_result_drain.sv
// Drains the engine's M x N result store in row-major order onto a valid/ready stream.
// Optional feature macro: DRAIN_NONFINITE_CNT_EN (count of drained Inf/NaN elements).
module matrix_result_drain #(
  parameter int MAX_M  = 100,
  parameter int MAX_N  = 100,
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  engine_done,
  input  logic [7:0]            M_val,
  input  logic [7:0]            N_val,
  output logic                  c_rd_en,
  output logic [ADDR_W-1:0]     c_rd_addr,
  input  logic [31:0]           c_rd_data,
  matrix_result_drain_if.master strm,
  output logic                  busy,
  output logic                  drain_done,
  output logic [15:0]           nonfinite_cnt
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t      state_reg;
  logic        done_q_reg;
  logic [7:0]  n_reg;
  logic [7:0]  c_reg;
  logic [15:0] total_reg;
  logic [15:0] idx_reg;
  logic        busy_reg;
  logic        drain_done_reg;

  logic        inflight_reg;
  logic        inflight_eol_reg;
  logic        inflight_last_reg;
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  fifo_cnt_reg;

  logic        trigger;
  logic        pop;
  logic        rd_eol;
  logic        rd_last;
  logic [7:0]  m_eff;
  logic [7:0]  n_eff;
  logic [15:0] total_next;
  logic [2:0]  occ;
  logic [31:0] head_data;
  logic        head_eol;
  logic        head_last;

  // Out-of-range sizes are clamped so reads never leave the engine's store.
  assign m_eff      = (int'(M_val) > MAX_M) ? 8'(MAX_M) : M_val;
  assign n_eff      = (int'(N_val) > MAX_N) ? 8'(MAX_N) : N_val;
  assign total_next = {8'd0, m_eff} * {8'd0, n_eff};

  assign trigger = (state_reg == IDLE) && engine_done && !done_q_reg;
  assign pop     = strm.out_valid && strm.out_ready;
  assign rd_eol  = (c_reg == n_reg - 8'd1);
  assign rd_last = (idx_reg == total_reg - 16'd1);
  assign occ     = 3'(fifo_cnt_reg) + 3'(inflight_reg);

  // Credit check counts the in-flight read so the 2-entry FIFO can never overflow.
  always_comb begin
    c_rd_en = 1'b0;
    if (state_reg == READ && (occ - 3'(pop)) < 3'd2)
      c_rd_en = 1'b1;
  end

  assign c_rd_addr  = ADDR_W'(idx_reg);
  assign busy       = busy_reg;
  assign drain_done = drain_done_reg;

  // done_q resets high so a level held across reset does not look like a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      done_q_reg     <= 1'b1;
      n_reg          <= '0;
      c_reg          <= '0;
      total_reg      <= '0;
      idx_reg        <= '0;
      busy_reg       <= 1'b0;
      drain_done_reg <= 1'b0;
    end else begin
      done_q_reg     <= engine_done;
      drain_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            n_reg     <= n_eff;
            total_reg <= total_next;
            idx_reg   <= '0;
            c_reg     <= '0;
            if (m_eff == 8'd0 || n_eff == 8'd0) begin
              state_reg      <= DONE;
              drain_done_reg <= 1'b1;
            end else begin
              state_reg <= READ;
              busy_reg  <= 1'b1;
            end
          end
        end
        READ: begin
          if (c_rd_en) begin
            idx_reg <= idx_reg + 16'd1;
            c_reg   <= rd_eol ? 8'd0 : c_reg + 8'd1;
            if (rd_last)
              state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && head_last) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            drain_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg      <= 1'b0;
      inflight_eol_reg  <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      fifo_cnt_reg      <= '0;
    end else begin
      inflight_reg      <= c_rd_en;
      inflight_eol_reg  <= rd_eol;
      inflight_last_reg <= rd_last;
      if (inflight_reg)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [33:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          entry_reg <= '0;
        else if (inflight_reg && (wr_ptr_reg == 1'(gi)))
          entry_reg <= {inflight_last_reg, inflight_eol_reg, c_rd_data};
      end
    end
  endgenerate

  assign {head_last, head_eol, head_data} = rd_ptr_reg ? g_entry[1].entry_reg
                                                       : g_entry[0].entry_reg;

  assign strm.out_valid = (fifo_cnt_reg != 2'd0);
  assign strm.out_data  = head_data;
  assign strm.out_eol   = head_eol;
  assign strm.out_last  = head_last;

`ifdef DRAIN_NONFINITE_CNT_EN
  logic [15:0] nf_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nf_cnt_reg <= '0;
    else if (trigger)
      nf_cnt_reg <= '0;
    else if (pop && head_data[30:23] == 8'hFF && nf_cnt_reg != 16'hFFFF)
      nf_cnt_reg <= nf_cnt_reg + 16'd1;
  end

  assign nonfinite_cnt = nf_cnt_reg;
`else
  assign nonfinite_cnt = 16'd0;
`endif

endmodule
